shared_counters_host: RTL

Host-side initiator for the shared counter bank, sitting between a simple request/response client and the bank's command port. It accepts one high-level operation at a time (allocate, deallocate, increment burst, read) and sequences `command_in`/`id`/`new_counter_size` cycle by cycle. It captures the bank's allocation result, and reassembles the G-bit `rdata_out` read stream into one W-bit value. It returns a single response per request, with timeout and overflow error reporting.

---
 rtl/shared_counters_pkg.sv | 41 ++++
 rtl/shared_counters_rd_asm.sv | 69 ++++++
 rtl/shared_counters_host.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/shared_counters_pkg.sv
// Shared definitions for the shared counter bank host: bank command
// encodings, client request opcodes and the host FSM state set.
package shared_counters_pkg;

    localparam logic [2:0] CMD_IDLE    = 3'b000;
    localparam logic [2:0] CMD_INC     = 3'b001;
    localparam logic [2:0] CMD_NEW     = 3'b010;
    localparam logic [2:0] CMD_DEALLOC = 3'b011;
    localparam logic [2:0] CMD_LOAD    = 3'b100;
    localparam logic [2:0] CMD_READ    = 3'b101;

    typedef enum logic [1:0] {
        OP_NEW     = 2'd0,
        OP_DEALLOC = 2'd1,
        OP_INC     = 2'd2,
        OP_READ    = 2'd3
    } req_op_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_NEW_CMD     = 3'd1,
        ST_WAIT_ALLOC  = 3'd2,
        ST_DEALLOC_CMD = 3'd3,
        ST_INC_RUN     = 3'd4,
        ST_READ_RUN    = 3'd5,
        ST_GAP         = 3'd6,
        ST_RESP        = 3'd7
    } state_e;

    // True for bank commands that address a counter through the id port.
    // LOAD is listed for completeness even though this host never issues it.
    function automatic logic cmd_uses_id(input logic [2:0] cmd);
        logic r;
        case (cmd)
            CMD_INC, CMD_DEALLOC, CMD_READ, CMD_LOAD: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shared_counters_rd_asm.sv
// Read reassembly: places G-bit read beats into a W-bit word, LSB chunk
// first, and flags any beat that no longer fits.
module shared_counters_rd_asm
    import shared_counters_pkg::*;
#(
    parameter int G = 4,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         beat_i,
    input  logic [G-1:0] chunk_i,
    output logic [W-1:0] data_o,
    output logic         ovf_o
);

    localparam int NB = W / G;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] NB_C = CW'(NB);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_q, data_d;
    logic          ovf_q, ovf_d;

    // Beat placement: the counter saturates at NB, beyond which beats are dropped
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        if (clear_i) begin
            cnt_d  = {CW{1'b0}};
            data_d = {W{1'b0}};
            ovf_d  = 1'b0;
        end else if (beat_i) begin
            if (cnt_q == NB_C) begin
                ovf_d = 1'b1;
            end else begin
                for (int k = 0; k < NB; k++) begin
                    if (cnt_q == CW'(k)) begin
                        data_d[k*G +: G] = chunk_i;
                    end else begin
                        data_d[k*G +: G] = data_q[k*G +: G];
                    end
                end
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Reassembly state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {CW{1'b0}};
            data_q <= {W{1'b0}};
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data_o = data_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/shared_counters_host.sv
// Host-side initiator for the shared counter bank: accepts one client
// operation at a time, sequences the bank command port and returns a
// single response with error reporting.
module shared_counters_host
    import shared_counters_pkg::*;
#(
    parameter int N       = 10,
    parameter int G       = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64,
    localparam int IDW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_op,
    input  logic [IDW-1:0] req_id,
    input  logic [31:0]    req_arg,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [1:0]     rsp_op,
    output logic [IDW:0]   rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic [2:0]     command_in,
    output logic [IDW-1:0] id,
    output logic [31:0]    new_counter_size,
    input  logic [IDW:0]   allocation_id,
    input  logic           valid_allocation_id,
    input  logic [G-1:0]   rdata_out,
    input  logic           valid_data_out,
    input  logic           last
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [IDW:0]  N_ID     = (IDW+1)'(N);

    state_e         state_q, state_d;
    logic [31:0]    inc_q, inc_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [IDW-1:0] req_id_q, req_id_d;
    logic [1:0]     rsp_op_q, rsp_op_d;
    logic [IDW:0]   rsp_id_q, rsp_id_d;
    logic           rsp_err_q, rsp_err_d;
    logic           req_ready_q, req_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [2:0]     cmd_q, cmd_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    size_q, size_d;
    logic           clear_s, beat_s, asm_ovf_s;
    logic [W-1:0]   asm_data_s;

    shared_counters_rd_asm #(.G(G), .W(W)) u_rd_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear_s),
        .beat_i  (beat_s),
        .chunk_i (rdata_out),
        .data_o  (asm_data_s),
        .ovf_o   (asm_ovf_s)
    );

    // FSM next state, request latch, wait timer and response bookkeeping
    always_comb begin
        state_d   = state_q;
        inc_d     = inc_q;
        tmo_d     = tmo_q;
        req_id_d  = req_id_q;
        rsp_op_d  = rsp_op_q;
        rsp_id_d  = rsp_id_q;
        rsp_err_d = rsp_err_q;
        clear_s   = 1'b0;
        beat_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    clear_s   = 1'b1;
                    req_id_d  = req_id;
                    rsp_op_d  = req_op;
                    rsp_id_d  = {1'b0, req_id};
                    rsp_err_d = 1'b0;
                    inc_d     = req_arg;
                    tmo_d     = {TW{1'b0}};
                    case (req_op)
                        OP_NEW:     state_d = ST_NEW_CMD;
                        OP_DEALLOC: state_d = ST_DEALLOC_CMD;
                        OP_INC:     state_d = ST_INC_RUN;
                        OP_READ:    state_d = ST_READ_RUN;
                        default:    state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_NEW_CMD: begin
                state_d = ST_WAIT_ALLOC;
            end
            ST_WAIT_ALLOC: begin
                if (valid_allocation_id) begin
                    rsp_id_d = allocation_id;
                    if (allocation_id >= N_ID) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_err_d = rsp_err_q;
                    end
                    state_d = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_err_d = 1'b1;
                    state_d   = ST_GAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DEALLOC_CMD: begin
                state_d = ST_GAP;
            end
            ST_INC_RUN: begin
                // inc_q counts the command cycles still to issue; zero on entry means none
                if (inc_q == 32'd0) begin
                    state_d = ST_RESP;
                end else begin
                    inc_d = inc_q - 32'd1;
                    if (inc_q == 32'd1) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_INC_RUN;
                    end
                end
            end
            ST_READ_RUN: begin
                if (valid_data_out) begin
                    beat_s = 1'b1;
                    tmo_d  = {TW{1'b0}};
                    if (last) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_READ_RUN;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    rsp_err_d = 1'b1;
                    state_d   = ST_GAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_GAP: begin
                // Read overflow is folded in here, after the final beat has been placed
                rsp_err_d = rsp_err_q | asm_ovf_s;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bank-side and handshake outputs derived from the upcoming state
    always_comb begin
        case (state_d)
            ST_NEW_CMD:     cmd_d = CMD_NEW;
            ST_DEALLOC_CMD: cmd_d = CMD_DEALLOC;
            ST_READ_RUN:    cmd_d = CMD_READ;
            ST_INC_RUN: begin
                if (inc_d != 32'd0) begin
                    cmd_d = CMD_INC;
                end else begin
                    cmd_d = CMD_IDLE;
                end
            end
            default:        cmd_d = CMD_IDLE;
        endcase
        if (cmd_uses_id(cmd_d)) begin
            id_d = req_id_d;
        end else begin
            id_d = {IDW{1'b0}};
        end
        if (cmd_d == CMD_NEW) begin
            size_d = req_arg;
        end else begin
            size_d = 32'd0;
        end
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State and registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            inc_q       <= 32'd0;
            tmo_q       <= {TW{1'b0}};
            req_id_q    <= {IDW{1'b0}};
            rsp_op_q    <= 2'd0;
            rsp_id_q    <= {(IDW+1){1'b0}};
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            cmd_q       <= CMD_IDLE;
            id_q        <= {IDW{1'b0}};
            size_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            inc_q       <= inc_d;
            tmo_q       <= tmo_d;
            req_id_q    <= req_id_d;
            rsp_op_q    <= rsp_op_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_q       <= cmd_d;
            id_q        <= id_d;
            size_q      <= size_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_op           = rsp_op_q;
    assign rsp_id           = rsp_id_q;
    assign rsp_data         = asm_data_s;
    assign rsp_err          = rsp_err_q;
    assign command_in       = cmd_q;
    assign id               = id_q;
    assign new_counter_size = size_q;

endmodule
